// File: rtl/disp_pkg.sv
// Shared encodings for the clock display/keypad scheduler: modes, blank code, field masks.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package disp_pkg;

  typedef logic [2:0] mode_t;

  localparam logic [2:0] M_TIME     = 3'd0;
  localparam logic [2:0] M_TIME_SET = 3'd1;
  localparam logic [2:0] M_CAL      = 3'd2;
  localparam logic [2:0] M_CAL_SET  = 3'd3;
  localparam logic [2:0] M_ALM      = 3'd4;
  localparam logic [2:0] M_ALM_SET  = 3'd5;
  localparam logic [2:0] M_CNTD     = 3'd6;

  // hex8 renders this nibble as an unlit digit
  localparam logic [3:0]  BLANK      = 4'hB;
  localparam logic [31:0] BLANK_WORD = {8{BLANK}};

  // Nibble masks of each edit field, indexed by Field (entry 3 never selected).
  // Clock layout: hh at [31:24], mm at [19:12], ss at [7:0].
  localparam logic [3:0][31:0] CLK_MASK = {32'h0000_0000, 32'h0000_00FF,
                                           32'h000F_F000, 32'hFF00_0000};
  // Calendar layout: field 0 at [31:24], field 1 at [23:16], field 2 at [15:0].
  localparam logic [3:0][31:0] CAL_MASK = {32'h0000_0000, 32'h0000_FFFF,
                                           32'h00FF_0000, 32'hFF00_0000};

  // Odd encodings 1, 3, 5 are the edit modes; 7 is unused
  function automatic logic is_set(input logic [2:0] m);
    return m[0] && (m != 3'd7);
  endfunction

endpackage

// File: rtl/disp_mode_sched_if.sv
// Bundle of key, source, display and command signals between scheduler and clock blocks.
// Latency: n/a (wiring only).
// Backpressure: none; all keys and commands are one-cycle pulses or levels.
interface disp_mode_sched_if;
  import disp_pkg::*;

  logic        Key_mode;
  logic        Key_field;
  logic        Key_up;
  logic        Key_dn;
  logic        Tick_1s;
  logic [31:0] Src_time;
  logic [31:0] Src_cal;
  logic [31:0] Src_alarm;
  logic [31:0] Src_cntd;
  logic        Alarm_ring;
  logic [31:0] Disp_Data;
  mode_t       Mode;
  logic [1:0]  Field;
  logic [2:0]  Inc;
  logic [2:0]  Dec;
  logic        Alarm_ack;
  logic        Cntd_run;
  logic        Cntd_clr;

  // scheduler side
  modport master (
    input  Key_mode, Key_field, Key_up, Key_dn, Tick_1s,
    input  Src_time, Src_cal, Src_alarm, Src_cntd, Alarm_ring,
    output Disp_Data, Mode, Field, Inc, Dec, Alarm_ack, Cntd_run, Cntd_clr
  );

  // key filter, time base, data sources and display side
  modport slave (
    output Key_mode, Key_field, Key_up, Key_dn, Tick_1s,
    output Src_time, Src_cal, Src_alarm, Src_cntd, Alarm_ring,
    input  Disp_Data, Mode, Field, Inc, Dec, Alarm_ack, Cntd_run, Cntd_clr
  );
endinterface

// File: rtl/disp_field_blank.sv
// Replaces the nibbles of the selected edit field with the blank code during the blank phase.
// Latency: combinational.
// Backpressure: none.
module disp_field_blank
  import disp_pkg::*;
(
  input  logic [31:0] word,
  input  logic        cal_layout,
  input  logic [1:0]  field,
  input  logic        blank,
  output logic [31:0] out_word
);

  logic [31:0] mask;

  // Pick the field mask for the active layout and substitute BLANK under it
  always_comb begin
    mask     = cal_layout ? CAL_MASK[field] : CLK_MASK[field];
    out_word = blank ? ((word & ~mask) | (BLANK_WORD & mask)) : word;
  end

endmodule

// File: rtl/disp_mode_sched.sv
// Mode FSM and hex8 display/keypad sharing for the clock; EDIT_TIMEOUT_EN adds edit auto-exit.
// Latency: 1 cycle from key pulse to Inc/Dec/Mode, 1 cycle from source/state to Disp_Data.
// Backpressure: none; keys are consumed on arrival, lower-priority pulses in a cycle are dropped.
module disp_mode_sched
  import disp_pkg::*;
#(
  parameter int BLINK_HALF = 12_500_000,
  parameter int TIMEOUT_S  = 10
) (
  input logic                  Clk,
  input logic                  Reset,
  disp_mode_sched_if.master    io
);

  localparam int BW = $clog2(2 * BLINK_HALF);

  mode_t       mode;
  logic [1:0]  field;
  logic [2:0]  inc;
  logic [2:0]  dec;
  logic        alarm_ack;
  logic        cntd_run;
  logic        cntd_clr;
  logic [31:0] disp;
  logic [BW-1:0] blink_cnt;
  logic        blank_ph;
  logic        any_key;
  logic        set_mode;
  logic        to_fire;
  logic [31:0] src_word;
  logic        cal_layout;
  logic [31:0] blanked;

  assign any_key  = io.Key_mode | io.Key_field | io.Key_up | io.Key_dn;
  assign set_mode = is_set(mode);
  assign blank_ph = (blink_cnt >= BW'(BLINK_HALF));

  // Free-running blink period; the second half is the blank phase
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(2 * BLINK_HALF - 1)) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

`ifdef EDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);

  logic [TW-1:0] to_cnt;

  // The last tick before the limit fires the exit; a same-cycle key pre-empts it in the FSM
  assign to_fire = set_mode && io.Tick_1s && (to_cnt == TW'(TIMEOUT_S - 1));

  // Seconds since the last key in an edit mode; held at zero while the alarm rings
  always_ff @(posedge Clk) begin
    if (Reset || io.Alarm_ring || !set_mode || any_key || to_fire) begin
      to_cnt <= '0;
    end else if (io.Tick_1s) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  logic unused_tick;

  assign to_fire     = 1'b0;
  assign unused_tick = io.Tick_1s;
`endif

  // Mode/field state, prioritised key routing and countdown control
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode      <= M_TIME;
      field     <= 2'd0;
      inc       <= 3'd0;
      dec       <= 3'd0;
      alarm_ack <= 1'b0;
      cntd_run  <= 1'b0;
      cntd_clr  <= 1'b0;
    end else begin
      inc       <= 3'd0;
      dec       <= 3'd0;
      alarm_ack <= 1'b0;
      cntd_clr  <= 1'b0;
      if (io.Alarm_ring) begin
        alarm_ack <= any_key;
      end else if (mode == 3'd7) begin
        mode  <= M_TIME;
        field <= 2'd0;
      end else if (io.Key_mode) begin
        mode  <= (mode == M_CNTD) ? M_TIME : mode + 3'd1;
        field <= 2'd0;
      end else if (io.Key_field) begin
        if (set_mode) begin
          field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
        end
      end else if (io.Key_up) begin
        if (set_mode) begin
          inc <= 3'd1 << field;
        end else if (mode == M_CNTD) begin
          cntd_run <= ~cntd_run;
        end
      end else if (io.Key_dn) begin
        if (set_mode) begin
          dec <= 3'd1 << field;
        end else if (mode == M_CNTD) begin
          cntd_clr <= 1'b1;
          cntd_run <= 1'b0;
        end
      end else if (to_fire) begin
        // each edit mode sits one encoding above its view mode
        mode  <= mode - 3'd1;
        field <= 2'd0;
      end
    end
  end

  // Source word and its field layout for the current mode
  always_comb begin
    src_word   = io.Src_time;
    cal_layout = 1'b0;
    case (mode)
      M_CAL, M_CAL_SET: begin
        src_word   = io.Src_cal;
        cal_layout = 1'b1;
      end
      M_ALM, M_ALM_SET: src_word = io.Src_alarm;
      M_CNTD:           src_word = io.Src_cntd;
      default: ;
    endcase
  end

  disp_field_blank u_field_blank (
    .word       (src_word),
    .cal_layout (cal_layout),
    .field      (field),
    .blank      (blank_ph && set_mode),
    .out_word   (blanked)
  );

  // Registered display word; a ringing alarm flashes the setpoint over everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp <= BLANK_WORD;
    end else if (io.Alarm_ring) begin
      disp <= blank_ph ? BLANK_WORD : io.Src_alarm;
    end else begin
      disp <= blanked;
    end
  end

  assign io.Disp_Data = disp;
  assign io.Mode      = mode;
  assign io.Field     = field;
  assign io.Inc       = inc;
  assign io.Dec       = dec;
  assign io.Alarm_ack = alarm_ack;
  assign io.Cntd_run  = cntd_run;
  assign io.Cntd_clr  = cntd_clr;

endmodule

// File: tb/tb_disp_mode_sched.sv
// Directed bench for disp_mode_sched with BLINK_HALF=4 and TIMEOUT_S=3.
// Expected values are hand-derived constants plus a small display model.
// EDIT_TIMEOUT_EN selects which timeout outcome is expected.
module tb_disp_mode_sched;
  import disp_pkg::*;

  localparam logic [31:0] S_TIME = 32'h1203_4056;
  localparam logic [31:0] S_CAL  = 32'h2509_0401;
  localparam logic [31:0] S_ALM  = 32'h0701_5030;
  localparam logic [31:0] S_CNTD = 32'h0009_9059;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_MODE  = 4'b1000;
  localparam logic [3:0] K_FIELD = 4'b0100;
  localparam logic [3:0] K_UP    = 4'b0010;
  localparam logic [3:0] K_DN    = 4'b0001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   nblank;

  logic [2:0] mode_tbl [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};

  // blink model: 8-cycle period, phase seen by the display at the last edge
  logic [2:0] mblink;
  logic       mph;

  disp_mode_sched_if bus();

  disp_mode_sched #(.BLINK_HALF(4), .TIMEOUT_S(3)) dut (
    .Clk   (clk),
    .Reset (rst),
    .io    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mblink <= 3'd0;
      mph    <= 1'b0;
    end else begin
      mblink <= mblink + 3'd1;
      mph    <= mblink[2];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic t);
    {bus.Key_mode, bus.Key_field, bus.Key_up, bus.Key_dn} = k;
    bus.Tick_1s = t;
    step();
    {bus.Key_mode, bus.Key_field, bus.Key_up, bus.Key_dn} = 4'b0000;
    bus.Tick_1s = 1'b0;
  endtask

  function automatic logic [31:0] model_disp(input logic [2:0] m, input logic [1:0] f,
                                             input logic bph, input logic ring);
    logic [31:0] w;
    if (ring) return bph ? 32'hBBBB_BBBB : S_ALM;
    case (m)
      3'd0, 3'd1: w = S_TIME;
      3'd2, 3'd3: w = S_CAL;
      3'd4, 3'd5: w = S_ALM;
      default:    w = S_CNTD;
    endcase
    if (bph && (m == 3'd1 || m == 3'd3 || m == 3'd5)) begin
      if (f == 2'd0) w[31:24] = 8'hBB;
      else if (m == 3'd3) begin
        if (f == 2'd1) w[23:16] = 8'hBB;
        else           w[15:0]  = 16'hBBBB;
      end else begin
        if (f == 2'd1) w[19:12] = 8'hBB;
        else           w[7:0]   = 8'hBB;
      end
    end
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got=still running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] ef;
    rst = 1'b1;
    {bus.Key_mode, bus.Key_field, bus.Key_up, bus.Key_dn} = 4'b0000;
    bus.Tick_1s    = 1'b0;
    bus.Alarm_ring = 1'b0;
    bus.Src_time   = S_TIME;
    bus.Src_cal    = S_CAL;
    bus.Src_alarm  = S_ALM;
    bus.Src_cntd   = S_CNTD;
    step();
    step();

    // reset state
    check_eq("rst_mode",  32'(bus.Mode), 32'd0);
    check_eq("rst_field", 32'(bus.Field), 32'd0);
    check_eq("rst_inc",   32'(bus.Inc), 32'd0);
    check_eq("rst_dec",   32'(bus.Dec), 32'd0);
    check_eq("rst_ack",   32'(bus.Alarm_ack), 32'd0);
    check_eq("rst_run",   32'(bus.Cntd_run), 32'd0);
    check_eq("rst_clr",   32'(bus.Cntd_clr), 32'd0);
    check_eq("rst_disp",  bus.Disp_Data, 32'hBBBB_BBBB);
    rst = 1'b0;
    step();
    check_eq("disp_time", bus.Disp_Data, model_disp(3'd0, 2'd0, mph, 1'b0));

    // full mode ring; field is nonzero before the second step
    for (int i = 0; i < 7; i++) begin
      drive(K_MODE, 1'b0);
      check_eq("mode_seq",  32'(bus.Mode), 32'(mode_tbl[i]));
      check_eq("field_clr", 32'(bus.Field), 32'd0);
      ef = 2'd0;
      if (i == 0) begin
        drive(K_FIELD, 1'b0);
        check_eq("field_inc", 32'(bus.Field), 32'd1);
        ef = 2'd1;
      end
      step();
      check_eq("disp_seq", bus.Disp_Data, model_disp(mode_tbl[i], ef, mph, 1'b0));
    end

    // TIME_SET, field 1: inc/dec pulses and blinking of minutes
    drive(K_MODE, 1'b0);
    check_eq("tset_mode", 32'(bus.Mode), 32'd1);
    drive(K_FIELD, 1'b0);
    check_eq("tset_field", 32'(bus.Field), 32'd1);
    drive(K_UP, 1'b0);
    check_eq("up_inc", 32'(bus.Inc), 32'b010);
    check_eq("up_dec", 32'(bus.Dec), 32'd0);
    step();
    check_eq("inc_width", 32'(bus.Inc), 32'd0);
    drive(K_DN, 1'b0);
    check_eq("dn_dec", 32'(bus.Dec), 32'b010);
    check_eq("dn_inc", 32'(bus.Inc), 32'd0);
    step();
    check_eq("dec_width", 32'(bus.Dec), 32'd0);
    nblank = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("blink_disp", bus.Disp_Data, model_disp(3'd1, 2'd1, mph, 1'b0));
      if (bus.Disp_Data[19:12] == 8'hBB) nblank++;
    end
    check_eq("blink_duty", 32'(nblank), 32'd4);

    // CAL_SET, field 2 blanks the year nibbles
    drive(K_MODE, 1'b0);
    drive(K_MODE, 1'b0);
    check_eq("cset_mode", 32'(bus.Mode), 32'd3);
    drive(K_FIELD, 1'b0);
    drive(K_FIELD, 1'b0);
    check_eq("cset_field", 32'(bus.Field), 32'd2);
    for (int i = 0; i < 8; i++) begin
      step();
      if (mph) check_eq("cal_blank", bus.Disp_Data, 32'h2509_BBBB);
      else     check_eq("cal_show",  bus.Disp_Data, 32'h2509_0401);
    end

    // reset in the middle of an edit with a key held
    bus.Key_up = 1'b1;
    rst = 1'b1;
    step();
    check_eq("rme_inc",   32'(bus.Inc), 32'd0);
    check_eq("rme_dec",   32'(bus.Dec), 32'd0);
    check_eq("rme_mode",  32'(bus.Mode), 32'd0);
    check_eq("rme_field", 32'(bus.Field), 32'd0);
    check_eq("rme_disp",  bus.Disp_Data, 32'hBBBB_BBBB);
    rst = 1'b0;
    step();
    check_eq("rme_inc2", 32'(bus.Inc), 32'd0);
    check_eq("rme_dec2", 32'(bus.Dec), 32'd0);
    bus.Key_up = 1'b0;

    // edit timeout in CAL_SET
    drive(K_MODE, 1'b0);
    drive(K_MODE, 1'b0);
    drive(K_MODE, 1'b0);
    check_eq("to_enter", 32'(bus.Mode), 32'd3);
    drive(K_NONE, 1'b1);
    drive(K_NONE, 1'b1);
    check_eq("to_hold_a", 32'(bus.Mode), 32'd3);
    drive(K_FIELD, 1'b1);
    check_eq("to_key_wins", 32'(bus.Mode), 32'd3);
    check_eq("to_key_field", 32'(bus.Field), 32'd1);
    drive(K_NONE, 1'b1);
    drive(K_NONE, 1'b1);
    check_eq("to_hold_b", 32'(bus.Mode), 32'd3);
    drive(K_NONE, 1'b1);
`ifdef EDIT_TIMEOUT_EN
    check_eq("to_exit", 32'(bus.Mode), 32'd2);
    check_eq("to_exit_field", 32'(bus.Field), 32'd0);
`else
    check_eq("to_off_mode", 32'(bus.Mode), 32'd3);
    check_eq("to_off_field", 32'(bus.Field), 32'd1);
`endif

    // alarm preempt while editing the alarm setpoint
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(K_MODE, 1'b0);
    check_eq("aset_mode", 32'(bus.Mode), 32'd5);
    bus.Alarm_ring = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("ring_disp", bus.Disp_Data, model_disp(3'd5, 2'd0, mph, 1'b1));
    end
    drive(K_UP, 1'b0);
    check_eq("ring_inc",  32'(bus.Inc), 32'd0);
    check_eq("ring_ack",  32'(bus.Alarm_ack), 32'd1);
    check_eq("ring_mode", 32'(bus.Mode), 32'd5);
    step();
    check_eq("ack_width", 32'(bus.Alarm_ack), 32'd0);
    drive(K_MODE, 1'b0);
    check_eq("ring_mode_frozen", 32'(bus.Mode), 32'd5);
    check_eq("ring_ack_mode", 32'(bus.Alarm_ack), 32'd1);
    step();
    bus.Alarm_ring = 1'b0;
    step();
    drive(K_UP, 1'b0);
    check_eq("resume_inc", 32'(bus.Inc), 32'b001);
    check_eq("resume_ack", 32'(bus.Alarm_ack), 32'd0);
    check_eq("resume_mode", 32'(bus.Mode), 32'd5);
    step();
    check_eq("resume_disp", bus.Disp_Data, model_disp(3'd5, 2'd0, mph, 1'b0));

    // countdown controls
    drive(K_MODE, 1'b0);
    check_eq("cntd_mode", 32'(bus.Mode), 32'd6);
    drive(K_UP, 1'b0);
    check_eq("run_on", 32'(bus.Cntd_run), 32'd1);
    drive(K_UP, 1'b0);
    check_eq("run_off", 32'(bus.Cntd_run), 32'd0);
    drive(K_UP, 1'b0);
    check_eq("run_on2", 32'(bus.Cntd_run), 32'd1);
    drive(K_DN, 1'b0);
    check_eq("clr_pulse", 32'(bus.Cntd_clr), 32'd1);
    check_eq("clr_stops", 32'(bus.Cntd_run), 32'd0);
    step();
    check_eq("clr_width", 32'(bus.Cntd_clr), 32'd0);
    check_eq("cntd_disp", bus.Disp_Data, model_disp(3'd6, 2'd0, mph, 1'b0));
    drive(K_MODE | K_DN, 1'b0);
    check_eq("prio_mode", 32'(bus.Mode), 32'd0);
    check_eq("prio_clr",  32'(bus.Cntd_clr), 32'd0);
    drive(K_UP, 1'b0);
    check_eq("time_up_run", 32'(bus.Cntd_run), 32'd0);
    check_eq("time_up_inc", 32'(bus.Inc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_mode_sched.md
Name: disp_mode_sched

Overview:
- Display/keypad scheduler for the electric clock.
- Owns the mode state machine and shares the single hex8 display between four data sources: time, calendar, alarm setpoint and countdown.
- Routes debounced key pulses as one-cycle increment/decrement commands to the selected field of the selected source.
- Preempts everything while the alarm rings and provides edit-field blinking and edit timeout.

Parameters:
BLINK_HALF, 12_500_000, Clk cycles per blink half-period (blank phase = second half)
TIMEOUT_S, 10, seconds without a key before a SET mode auto-exits
BLANK, 4'hB, nibble code hex8 renders as blank digit

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
Key_mode  in  1  one-cycle pulse from key_filter (Key_P_flag[3])
Key_field  in  1  one-cycle pulse (Key_P_flag[2])
Key_up  in  1  one-cycle pulse (Key_P_flag[1])
Key_dn  in  1  one-cycle pulse (Key_P_flag[0])
Tick_1s  in  1  one-cycle pulse per second from time base
Src_time  in  32  time display word, fields at [31:24],[19:12],[7:0]
Src_cal  in  32  calendar word, fields at [31:24],[23:16],[15:0]
Src_alarm  in  32  alarm setpoint word, same layout as Src_time
Src_cntd  in  32  countdown word, same layout as Src_time
Alarm_ring  in  1  level, high while alarm active
Disp_Data  out  32  to hex8 Disp_Data
Mode  out  3  current mode encoding
Field  out  2  selected edit field 0..2
Inc  out  3  one-hot per-field increment pulse to the target of Mode
Dec  out  3  one-hot per-field decrement pulse
Alarm_ack  out  1  one-cycle acknowledge to alarm block
Cntd_run  out  1  countdown run enable (level)
Cntd_clr  out  1  one-cycle countdown clear

Behaviour:
- Reset values: Mode=TIME, Field=0, Inc=Dec=0, Alarm_ack=0, Cntd_run=0, Cntd_clr=0, Disp_Data=32'hBBBB_BBBB.
- Blink counter and timeout counter are cleared by reset.
- Modes: TIME(0) -> TIME_SET(1) -> CAL(2) -> CAL_SET(3) -> ALM(4) -> ALM_SET(5) -> CNTD(6) -> TIME.
  - Key_mode advances the mode.
  - Encoding 7 -> TIME on the next cycle.
  - Field is cleared to 0 on every mode change.
- SET modes:
  - Key_field cycles Field 0->1->2->0.
  - Key_up / Key_dn produce Inc[Field] / Dec[Field] on the next cycle, exactly one cycle wide.
  - Target is implied by Mode: TIME_SET->time, CAL_SET->calendar, ALM_SET->alarm.
- Non-SET modes:
  - Key_field, Key_up and Key_dn are ignored, except in CNTD.
  - In CNTD, Key_up toggles Cntd_run and Key_dn pulses Cntd_clr for one cycle and forces Cntd_run=0.
- Simultaneous pulses: priority is mode > field > up > dn. Lower-priority pulses in the same cycle are dropped.
- Display source: TIME/TIME_SET->Src_time, CAL/CAL_SET->Src_cal, ALM/ALM_SET->Src_alarm, CNTD->Src_cntd.
- Disp_Data is registered with 1-cycle latency from source or state change.
- Blink:
  - Free-running counter 0..2*BLINK_HALF-1.
  - In SET modes during the second half, the nibbles of the selected field are forced to BLANK, using the layout of the active source.
- Alarm preempt:
  - While Alarm_ring=1, Disp_Data shows Src_alarm in the first blink half and all BLANK in the second half.
  - Mode and Field are frozen.
  - Any key pulse is consumed (no Inc/Dec/mode change) and generates Alarm_ack one cycle later.
  - When Alarm_ring falls, the frozen mode resumes and the timeout counter restarts.
- Timeout:
  - Counter counts Tick_1s in SET modes and clears on any key pulse or mode change.
  - Reaching TIMEOUT_S moves TIME_SET->TIME, CAL_SET->CAL, ALM_SET->ALM.
  - A tick and a key pulse in the same cycle: the key wins and the counter clears.
- Reset mid-edit: returns to TIME with no Inc/Dec emitted in the reset cycle or the cycle after.

Optional Feature:
- Macro: EDIT_TIMEOUT_EN.
- Defined: timeout logic as above.
- Undefined: SET modes persist until Key_mode, Tick_1s is unused, and no timeout counter is synthesized.

Decomposition:
- Shared package disp_pkg holds:
  - mode encodings TIME..CNTD;
  - BLANK code;
  - per-layout field nibble masks (clock layout and calendar layout) as 32-bit constants indexed by Field.
- One natural sub-module: disp_field_blank, combinational, applying the mask/BLANK substitution given word, layout, field and blank-phase.

Test Plan:
- Seven Key_mode pulses from reset -> Mode sequence 1,2,3,4,5,6,0; Field=0 after each step; Disp_Data follows the source one cycle later.
- TIME_SET with Field=1, then Key_up -> Inc=3'b010 for exactly one cycle, Dec=0. With BLINK_HALF=4, Disp_Data[19:12]=8'hBB during cycles 4..7 of the blink period.
- CAL_SET with Field=2, Src_cal=32'h2509_0401 -> blank phase shows 32'h2509_BBBB.
- Alarm_ring=1 while in ALM_SET, then Key_up -> no Inc, Alarm_ack pulses once, Mode stays 5. Alarm_ring=0 -> editing resumes.
- EDIT_TIMEOUT_EN defined, TIMEOUT_S=3, in CAL_SET:
  - 3 Tick_1s pulses -> Mode=2.
  - Repeat with a Key_field pulse in the same cycle as the 3rd tick -> Mode stays 3.
- CNTD: Key_up -> Cntd_run=1; Key_up -> 0; Key_up then Key_dn -> Cntd_clr one-cycle pulse and Cntd_run=0. Key_mode and Key_dn in the same cycle -> Mode=TIME, no Cntd_clr.
